// File: rtl/qc_uart_pkg.sv
// qc_uart_pkg: shared UART types and helpers for fabric-side RX/TX blocks.
package qc_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int baud_div(input longint clk_hz, input longint baud, input longint os);
    longint d;
    d = (clk_hz + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : int'(d);
  endfunction
endpackage

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: circular byte FIFO with a registered show-ahead head and valid.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  output logic                     full,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] dout_q, dout_d;
  logic empty_q, empty_d;
  logic wr_en, rd_en;
  assign count = wr_q - rd_q;
  assign full = count[AW];
  assign dout = dout_q;
  assign empty = empty_q;
  // The head register is loaded with whatever sits at the next read slot, bypassing the write when they coincide.
  always_comb begin
    rd_en = pop && !empty_q;
    wr_en = push && (!full || rd_en);
    wr_d = wr_q + (AW+1)'(wr_en);
    rd_d = rd_q + (AW+1)'(rd_en);
    empty_d = wr_d == rd_d;
    dout_d = empty_d ? '0 : (wr_en && wr_q[AW-1:0] == rd_d[AW-1:0]) ? din : mem_q[rd_d[AW-1:0]];
  end
  always_ff @(posedge clk) if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      dout_q <= '0;
      empty_q <= 1'b1;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      dout_q <= dout_d;
      empty_q <= empty_d;
    end
  end
endmodule

// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo: 16x oversampled 8N1 UART receiver feeding a byte FIFO stream.
module uart_rx_byte_fifo
  import qc_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9_600,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
);
  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  logic [1:0] sync_q, sync_d;
  logic [DW-1:0] div_q, div_d;
  rx_state_t state_q, state_d;
  logic [3:0] smp_q, smp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic armed_q, armed_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic rx, tick, push, full, empty;
  assign rx = sync_q[1];
  assign m_valid = !empty;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
  always_comb begin
    sync_d = {sync_q[0], rxd};
    tick = div_q == DW'(DIV - 1);
    div_d = tick ? '0 : div_q + DW'(1);
    armed_d = armed_q | rx;
    state_d = state_q;
    smp_d = tick ? smp_q + 4'd1 : smp_q;
    bit_d = bit_q;
    shift_d = shift_q;
    push = 1'b0;
    frame_err_d = 1'b0;
    // Start detection runs every clock so the divider can realign to the falling edge.
    if (state_q == IDLE && !rx && armed_q) begin
      state_d = START;
      smp_d = '0;
      div_d = '0;
    end else if (tick) begin
      case (state_q)
        START: begin
          if (smp_q == 4'd7 && rx) state_d = IDLE;
          else if (smp_q == 4'd15) begin
            state_d = DATA;
            bit_d = '0;
          end
        end
        DATA: begin
          if (smp_q == 4'd7) shift_d = {rx, shift_q[7:1]};
          if (smp_q == 4'd15) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
          end
        end
        STOP: begin
          if (smp_q == 4'd7) begin
            push = rx;
            frame_err_d = !rx;
            state_d = rx ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: state_d = rx ? IDLE : WAIT_IDLE;
        default: ;
      endcase
    end
    overrun_d = push && full && !(m_valid && m_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      div_q <= '0;
      state_q <= IDLE;
      smp_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      div_q <= div_d;
      state_q <= state_d;
      smp_q <= smp_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end
  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(shift_q),
    .full(full),
    .pop(m_ready),
    .dout(m_data),
    .empty(empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// tb_uart_rx_byte_fifo: table-driven and scoreboard checks of the UART RX byte FIFO.
module tb_uart_rx_byte_fifo;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, m_ready = 1'b0;
  logic [7:0] m_data;
  logic m_valid, frame_err, overrun;
  logic [4:0] fifo_count;
  int vectors = 0, miscompares = 0, ferr_n = 0, ovr_n = 0;
  logic [7:0] sb [$];
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    int         exp_ferr;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  uart_rx_byte_fifo #(
    .CLK_FREQ_HZ(16_000_000),
    .BAUD(1_000_000),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rxd(rxd),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fifo_count(fifo_count),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame, 16 clocks per bit; can stop early after max_cyc clocks.
  task automatic send(input logic [7:0] d, input logic stop, input int max_cyc);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 160 && i < max_cyc; i++) begin
      rxd = f[i/16];
      step(1);
    end
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 64 && m_valid; i++) step(1);
    m_ready = 1'b0;
    check("drain_valid", m_valid, 0);
    check("sb_left", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) ferr_n++;
      if (overrun) ovr_n++;
      if (frame_err && overrun) check("flags_together", 1, 0);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check("unexpected_byte", int'(m_data), -1);
        else check("pop_data", int'(m_data), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    int f0, o0;
    tbl[0] = '{8'hA5, 1'b1, 1, 0};
    tbl[1] = '{8'h3C, 1'b1, 2, 0};
    tbl[2] = '{8'h55, 1'b0, 2, 1};
    tbl[3] = '{8'h12, 1'b1, 3, 1};
    tbl[4] = '{8'hFF, 1'b1, 4, 1};
    tbl[5] = '{8'h00, 1'b1, 5, 1};
    // reset with m_ready toggling
    for (int i = 0; i < 6; i++) begin
      m_ready = ~m_ready;
      step(1);
    end
    m_ready = 1'b0;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    step(40);
    check("post_rst_count", fifo_count, 0);
    check("post_rst_valid", m_valid, 0);
    // table of frames accumulating in the FIFO
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].stop) sb.push_back(tbl[i].data);
      send(tbl[i].data, tbl[i].stop, 160);
      rxd = 1'b1;
      step(4);
      check("tbl_count", fifo_count, tbl[i].exp_count);
      check("tbl_ferr", ferr_n, tbl[i].exp_ferr);
    end
    drain();
    // single frame, one-clock pop
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1, 160);
    step(2);
    check("single_valid", m_valid, 1);
    check("single_data", m_data, 8'hA5);
    check("single_count", fifo_count, 1);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    check("single_pop_valid", m_valid, 0);
    check("single_pop_count", fifo_count, 0);
    // glitch
    f0 = ferr_n;
    rxd = 1'b0;
    step(4);
    rxd = 1'b1;
    step(40);
    check("glitch_count", fifo_count, 0);
    check("glitch_ferr", ferr_n, f0);
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1, 160);
    step(2);
    check("after_glitch_data", m_data, 8'h3C);
    drain();
    // framing error followed by a long break
    f0 = ferr_n;
    send(8'h55, 1'b0, 160);
    step(40);
    rxd = 1'b1;
    step(5);
    check("frame_ferr", ferr_n, f0 + 1);
    check("frame_count", fifo_count, 0);
    sb.push_back(8'h12);
    send(8'h12, 1'b1, 160);
    step(2);
    drain();
    // overrun: 17 back-to-back bytes
    o0 = ovr_n;
    f0 = ferr_n;
    for (int b = 0; b < 17; b++) begin
      if (b < 16) sb.push_back(8'(b));
      send(8'(b), 1'b1, 160);
    end
    step(4);
    check("ovr_count", fifo_count, 16);
    check("ovr_pulses", ovr_n, o0 + 1);
    check("ovr_ferr", ferr_n, f0);
    drain();
    // full FIFO with a pop on the push cycle of the 17th byte
    for (int b = 8'h20; b < 8'h30; b++) begin
      sb.push_back(8'(b));
      send(8'(b), 1'b1, 160);
    end
    step(2);
    check("full_count", fifo_count, 16);
    o0 = ovr_n;
    sb.push_back(8'hEE);
    fork
      send(8'hEE, 1'b1, 160);
      begin
        step(154);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
      end
    join
    step(2);
    check("same_cycle_ovr", ovr_n, o0);
    check("same_cycle_count", fifo_count, 16);
    drain();
    // reset in the middle of data bit 3
    send(8'h44, 1'b1, 160);
    step(2);
    check("pre_rst_count", fifo_count, 1);
    send(8'h99, 1'b1, 76);
    rst_n = 1'b0;
    sb.delete();
    step(3);
    check("midrst_count", fifo_count, 0);
    check("midrst_valid", m_valid, 0);
    check("midrst_data", m_data, 0);
    rst_n = 1'b1;
    rxd = 1'b1;
    step(20);
    sb.push_back(8'h81);
    send(8'h81, 1'b1, 160);
    step(2);
    check("after_rst_count", fifo_count, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
